// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch front end
// Rev 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int ENTRY_PC_W   = 32;
  localparam int ENTRY_INST_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer : DEPTH-entry synchronous FIFO; flush wins over push, after pop
// Rev 1.0
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, fetch FIFO and redirect / misalignment-fault control
// Rev 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                         PC_WIDTH_LENGTH   = 32,
  parameter int                         INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = PC_WIDTH_LENGTH'(DEFAULT_RESET_PC),
  parameter int                         BUF_DEPTH         = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH_LENGTH-1:0]   PC,
  input  logic [INST_WIDTH_LENGTH-1:0] inst,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_WIDTH_LENGTH-1:0] out_inst,
  output logic [PC_WIDTH_LENGTH-1:0]   out_pc,
  output logic                         misalign_fault
);

  localparam int ENTRY_W = PC_WIDTH_LENGTH + INST_WIDTH_LENGTH;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;

  fetch_state_e               state;
  fetch_state_e               state_next;
  logic [PC_WIDTH_LENGTH-1:0] pc_next;
  logic                       push;
  logic                       pop;
  logic                       buf_full;
  logic                       buf_empty;
  logic [CNT_W-1:0]           buf_count_unused;
  logic [ENTRY_W-1:0]         head;

  assign pop = out_valid && out_ready;

  // Redirect beats push; a pop in the same cycle still retires the head
  always_comb begin
    state_next = state;
    pc_next    = PC;
    push       = 1'b0;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) state_next = ST_FAULT;
      else                           state_next = ST_RUN;
    end else if ((state == ST_RUN) && (!buf_full || pop)) begin
      push    = 1'b1;
      pc_next = PC + PC_WIDTH_LENGTH'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      PC    <= RESET_PC;
    end else begin
      state <= state_next;
      PC    <= pc_next;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({PC, inst}),
    .rdata (head),
    .count (buf_count_unused),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign out_valid      = !buf_empty;
  assign out_pc         = head[ENTRY_W-1 -: PC_WIDTH_LENGTH];
  assign out_inst       = head[INST_WIDTH_LENGTH-1:0];
  assign misalign_fault = (state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : randomized bench for fetch_unit against a queue-based model
// Rev 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_fault;

  always #5 clk = ~clk;

  // memory holds the word index at each word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign inst = mem_word(PC);

  fetch_unit #(
    .PC_WIDTH_LENGTH   (32),
    .INST_WIDTH_LENGTH (32),
    .RESET_PC          (RST_PC),
    .BUF_DEPTH         (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC             (PC),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .misalign_fault (misalign_fault)
  );

  int errors = 0;
  int checks = 0;

  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic         m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = RST_PC;
    m_fault = 1'b0;
  endtask

  // one rising edge of the fetch front end, stated in queue terms
  task automatic model_edge();
    if ((m_q.size() != 0) && out_ready) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc;
      m_fault = (redirect_pc[1:0] != 2'b00);
    end else if (!m_fault && (m_q.size() < DEPTH)) begin
      m_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", out_inst, m_q[0].inst);
    end
    check("pc", PC, m_pc);
    check("fault", {31'b0, misalign_fault}, {31'b0, m_fault});
  endtask

  task automatic check_reset_values();
    check("rst_pc", PC, RST_PC);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_fault", {31'b0, misalign_fault}, 32'd0);
  endtask

  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic        rv;
    logic [31:0] rpc;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // backpressure from the first fetch
    cycle(1'b0, 32'd0, 1'b0);
    check("first_pc", out_pc, RST_PC);
    repeat (5) cycle(1'b0, 32'd0, 1'b0);
    check("stall_pc", PC, 32'd8);

    // free run
    repeat (8) cycle(1'b0, 32'd0, 1'b1);

    // redirect while full, popping in the same cycle
    repeat (3) cycle(1'b0, 32'd0, 1'b0);
    check("pop_valid", {31'b0, out_valid}, 32'd1);
    cycle(1'b1, 32'h100, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    check("redir_pc", out_pc, 32'h100);
    repeat (3) cycle(1'b0, 32'd0, 1'b1);

    // misaligned redirect and recovery
    cycle(1'b1, 32'h102, 1'b1);
    repeat (5) begin
      cycle(1'b0, 32'd0, 1'($urandom_range(0, 1)));
      check("fault_hold", {31'b0, misalign_fault}, 32'd1);
    end
    cycle(1'b1, 32'h200, 1'b1);
    check("fault_clear", {31'b0, misalign_fault}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    check("recover_pc", out_pc, 32'h200);

    // wrap-around
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    check("wrap0", out_pc, 32'hFFFF_FFF8);
    cycle(1'b0, 32'd0, 1'b1);
    check("wrap1", out_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1);
    check("wrap2", out_pc, 32'h0000_0000);

    // random traffic
    repeat (400) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cycle(rv, rpc, ($urandom_range(0, 3) != 0));
    end

    // make sure the stream is running, then reset between edges
    cycle(1'b1, 32'h0000_0400, 1'b1);
    repeat (3) cycle(1'b0, 32'd0, 1'b1);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'd0, 1'b1);
    check("post_rst_pc", out_pc, RST_PC);
    repeat (4) cycle(1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RISC-V core. It owns the program counter and drives `PC` into the combinational instruction memory, which returns `inst` in the same cycle. It buffers each fetched word with its address in a small FIFO and hands entries to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO, and any misaligned target is trapped into a fault state.

## Interface
Parameters:
- `PC_WIDTH_LENGTH`, 32: PC width in bits.
- `INST_WIDTH_LENGTH`, 32: instruction width in bits.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset. Must be word-aligned.
- `BUF_DEPTH`, 2: number of FIFO entries. Legal values are 2 and 4.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `PC`  out  PC_WIDTH_LENGTH  Fetch address to instruction memory.
- `inst`  in  INST_WIDTH_LENGTH  Memory data for `PC`, valid in the same cycle.
- `redirect_valid`  in  1  Redirect request, one-cycle pulse.
- `redirect_pc`  in  PC_WIDTH_LENGTH  Redirect target address.
- `out_valid`  out  1  FIFO head holds a valid entry.
- `out_ready`  in  1  Decode accepts the head this cycle.
- `out_inst`  out  INST_WIDTH_LENGTH  Instruction at the FIFO head.
- `out_pc`  out  PC_WIDTH_LENGTH  Address of `out_inst`.
- `misalign_fault`  out  1  High while in the FAULT state.

## Operation
- There are two states: RUN and FAULT.
- **RUN:**
  - Push condition: the FIFO is not full, or a pop happens this cycle.
  - On push, `{PC, inst}` is written into the FIFO and `PC <= PC + 4`.
  - If no push occurs, `PC` holds its value.
- **PC arithmetic:** the add is modulo 2^PC_WIDTH_LENGTH, so 32'hFFFF_FFFC + 4 wraps to 0.
- **Pop:** `out_valid && out_ready`. The head is removed at the clock edge.
- **Full FIFO:** a simultaneous push and pop is legal, and the occupancy stays at BUF_DEPTH.
- **Redirect:** when `redirect_valid` is high, redirect has priority over push in that cycle.
  - No push occurs.
  - A pop in the same cycle completes normally: the consumer owns that entry.
  - All remaining entries are flushed.
  - `PC <= redirect_pc`.
- **Misaligned target:** if `redirect_pc[1:0] != 0`, the FSM enters FAULT.
- **FAULT:**
  - No pushes.
  - The FIFO is empty, so `out_valid` = 0.
  - `PC` holds the faulting address.
  - `misalign_fault` = 1.
  - Only a redirect to an aligned target returns the FSM to RUN. A misaligned redirect keeps it in FAULT and updates `PC`.
- **`inst` handling:** `inst` is never examined for X/Z. Alignment is enforced only through `PC`, which is always aligned while in RUN.
- **Reset values:**
  - `PC` = RESET_PC.
  - FIFO empty: `out_valid` = 0.
  - `out_inst` = 0 and `out_pc` = 0. The storage is cleared.
  - `misalign_fault` = 0.
  - State = RUN.
- **Reset mid-operation:** reset asserted at any time returns every output to its reset value immediately (asynchronous). Any in-flight fetch is discarded.

## Timing
- **Fetch latency:** an instruction fetched in cycle N (`PC` = A) appears at the head with `out_valid` = 1 in cycle N+1, provided it is the oldest entry.
- **After reset release:**
  - First rising edge: the instruction at RESET_PC is pushed.
  - Cycle 1: `out_valid` = 1, `out_pc` = RESET_PC.
- **Redirect latency:** a redirect in cycle N gives:
  - Cycle N+1: `PC` = target.
  - Cycle N+2: `out_valid` = 1, `out_pc` = target. The redirect-to-use penalty is 2 cycles.
- **Steady state:** with `out_ready` held at 1, throughput is one instruction per cycle, and `out_pc` increments by 4 every cycle.
- **Backpressure:** with `out_ready` = 0, the FIFO fills in BUF_DEPTH cycles. `PC` then stalls at (last pushed address + 4).
- **Output timing:** all outputs are registered or derived only from state. There is no combinational path from `out_ready` or `redirect_valid` to any output.

## Structure
- **Shared package `fetch_pkg`:**
  - FSM state enum: RUN, FAULT.
  - `INST_BYTES` = 4.
  - Default `RESET_PC`.
  - FIFO entry struct: `{pc, inst}`.
- **Sub-module `fetch_buffer`:** a BUF_DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty.
  - Priority: flush takes priority over push but is applied after pop.
- The PC register and the FSM stay in `fetch_unit`.

## Test plan
- **Reset then free-run:** RESET_PC = 0, `out_ready` = 1, with memory holding the word index at each word.
  - Required: cycle 1 shows `out_pc` = 0.
  - Each following cycle shows `out_pc` += 4, with `out_inst` matching memory.
- **Backpressure:** hold `out_ready` = 0 for 6 cycles, then release.
  - Required: `PC` stalls at 8.
  - Entries 0 and 4 are kept, with none lost or duplicated.
  - After release the sequence resumes at 8.
- **Redirect while full, with pop in the same cycle:** redirect to 32'h100.
  - Required: the popped entry is delivered.
  - The FIFO is flushed.
  - Two cycles later, `out_pc` = 32'h100.
- **Misaligned redirect:** redirect to 32'h102.
  - Required: `misalign_fault` = 1 and `out_valid` = 0 for all following cycles.
  - After a redirect to 32'h200, `misalign_fault` drops the next cycle, and `out_pc` = 32'h200 appears 2 cycles after the redirect.
- **Wrap-around:** redirect to 32'hFFFF_FFF8.
  - Required: `out_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Asynchronous reset mid-stream:** assert `rst_n` = 0 between clock edges.
  - Required: all outputs return to reset values immediately.
  - After release, the first entry has `out_pc` = RESET_PC.
